spi_cmd_slave: RTL
==================

# spi_cmd_slave

SPI responder that terminates the Raspberry Pi command link inside the design. It oversamples the master's SCK/MOSI/SS pins on the system clock, reassembles each 16-bit frame into an 8-bit register address and 8-bit data byte, and issues a one-cycle command strobe to the register file. In the same frame it shifts a 16-bit readback word out on MISO.

## Interface
- SYNC_STAGES, 2, flip-flops in each input synchronizer (min 2)
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- spi_sck_i  in  1  master SCK, asynchronous, idles high
- spi_mosi_i  in  1  master-out data, asynchronous
- spi_ss_i  in  1  slave select, asynchronous, active low
- spi_miso_o  out  1  slave-out data
- spi_miso_oe_o  out  1  MISO drive enable (high while a frame is active)
- tx_word_i  in  16  readback word, sampled at frame start
- cmd_addr_o  out  8  address byte of last good frame
- cmd_data_o  out  8  data byte of last good frame
- cmd_valid_o  out  1  one-cycle strobe: new command on cmd_addr_o/cmd_data_o
- frame_err_o  out  1  one-cycle strobe: frame ended with bit count ≠ 16
- busy_o  out  1  high from detected SS fall to detected SS rise

## Operation
- SPI mode 3: CPOL=1, CPHA=1, MSB first. Slave samples MOSI on SCK rising edges and updates MISO on SCK falling edges.
- Wire byte order is low byte first. The master sends {cmd[7:0], cmd[15:8]}. With received shift register r[15:0] (first bit in r[15]), the command is {r[7:0], r[15:8]}, so cmd_addr_o = r[7:0] and cmd_data_o = r[15:8].
- Synchronizers: SYNC_STAGES flops on each of SCK, MOSI and SS, plus one history flop each on SCK and SS for edge detection. All internal logic uses only synchronized signals.
- FSM states:
  - WAIT_IDLE: entered from reset. Moves to IDLE once synced SS = 1.
  - IDLE: on detected SS fall, load tx_shift ← {tx_word_i[7:0], tx_word_i[15:8]}, clear bit_cnt and the seen_rise flag, then go to SHIFT.
  - SHIFT:
    - Detected SCK rise: r ← {r[14:0], mosi_sync}; bit_cnt +1, saturating at 31; set seen_rise.
    - Detected SCK fall with seen_rise set: tx_shift ← {tx_shift[14:0], 0}.
    - SCK fall before the first rise is ignored.
    - Detected SS rise: go to DONE.
  - DONE (one cycle):
    - If bit_cnt = 16: update cmd_addr_o/cmd_data_o and pulse cmd_valid_o.
    - Otherwise: pulse frame_err_o and leave the outputs unchanged.
    - Then go to IDLE.
- spi_miso_o = tx_shift[15] while in SHIFT, otherwise 0. spi_miso_oe_o = 1 only in SHIFT.
- busy_o = 1 in SHIFT and DONE.
- SS fall and SS rise detected in the same cycle cannot occur; the edge detector produces at most one SS edge per cycle.
- SCK edge and SS rise in the same cycle: process the SCK edge first (count the bit), then evaluate the count in DONE.

## Timing
- Reset values:
  - spi_miso_o = 0, spi_miso_oe_o = 0
  - cmd_addr_o = 0x00, cmd_data_o = 0x00
  - cmd_valid_o = 0, frame_err_o = 0, busy_o = 0
  - All synchronizers reset to idle levels (SCK=1, SS=1, MOSI=0); FSM state = WAIT_IDLE.
- Edge detect latency: SYNC_STAGES+1 clk cycles from pin edge to internal action (3 at default).
- cmd_valid_o rises SYNC_STAGES+2 cycles after the SS pin rises.
- MISO is valid SYNC_STAGES+2 cycles after the pin event (SS fall or SCK fall).
- Master requirements, stated as bench constraints:
  - SCK high and low phases each ≥ 2·(SYNC_STAGES+2) clk periods.
  - SS setup to first SCK fall ≥ the same.
  - SS high between frames ≥ SYNC_STAGES+3 clk periods.
  - Violations are not detected.
- Reset mid-frame: FSM goes to WAIT_IDLE and any partial frame is discarded. No strobe is issued until a complete new frame starts after SS has been seen high.
- cmd_valid_o has no backpressure; the consumer must accept it in the strobe cycle.

## Test plan
- Reset then frame cmd 0x2001 (wire bits 0x01 then 0x20) -> exactly one cmd_valid_o pulse with addr 0x20, data 0x01; frame_err_o never asserts.
- tx_word_i = 0xA55A held at SS fall; master captures 16 bits on SCK rises -> received 0x5AA5 (0x5A then 0xA5); spi_miso_oe_o = 0 outside the frame.
- 8-bit frame, then 17-bit frame -> two frame_err_o pulses, no cmd_valid_o; outputs retain the prior 0x20/0x01.
- Back-to-back frames 0x1307 then 0x1300 with minimum SS gap -> two cmd_valid_o pulses: (0x13,0x07) then (0x13,0x00).
- reset_i pulsed after 9 bits of a frame, SS held low, remaining bits sent -> no strobes. The next full frame 0x1101 -> cmd_valid_o with (0x11,0x01).
- Random 16-bit commands (≥200) at the minimum legal SCK rate -> every strobe matches the byte-swapped reference model; cmd_valid_o latency = SYNC_STAGES+2 cycles from SS rise.

Source files
------------

// File: rtl/spi_cmd_slave.sv
// SPI mode-3 command responder: oversamples SCK/MOSI/SS on clk_i, assembles
// 16-bit frames into an address/data command strobe and shifts a readback
// word out on MISO during the same frame.
module spi_cmd_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        spi_sck_i,
    input  logic        spi_mosi_i,
    input  logic        spi_ss_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    input  logic [15:0] tx_word_i,
    output logic [7:0]  cmd_addr_o,
    output logic [7:0]  cmd_data_o,
    output logic        cmd_valid_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned CNT_MAX      = 31;
    // After reset the synchronizers hold idle levels that may not match the
    // pins; wait until the real pin level has flushed through before trusting SS.
    localparam int unsigned FLUSH_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned FLUSH_W      = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sck_hist_q, ss_hist_q;
    logic                   sck_s, mosi_s, ss_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    logic [15:0]        rx_q, rx_d;
    logic [15:0]        tx_q, tx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [7:0]         addr_d, data_d;
    logic               valid_d, err_d, miso_d, oe_d, busy_d;

    // Input synchronizers plus one history flop for SCK/SS edge detection
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_sync_q  <= '1;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b1;
            ss_hist_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign ss_rise  = ss_s & ~ss_hist_q;
    assign ss_fall  = ~ss_s & ss_hist_q;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_WAIT_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_IDLE: if (flush_q == FLUSH_W'(FLUSH_CYCLES) && ss_s) state_d = ST_IDLE;
            ST_IDLE:      if (ss_fall) state_d = ST_SHIFT;
            ST_SHIFT:     if (ss_rise) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_WAIT_IDLE;
        endcase
    end

    // Datapath and output next values; SCK edges are handled before SS rise
    always_comb begin
        rx_d    = rx_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        flush_d = flush_q;
        addr_d  = cmd_addr_o;
        data_d  = cmd_data_o;
        valid_d = 1'b0;
        err_d   = 1'b0;
        miso_d  = (state_q == ST_SHIFT) ? tx_q[15] : 1'b0;
        oe_d    = (state_q == ST_SHIFT);
        busy_d  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        unique case (state_q)
            ST_WAIT_IDLE: begin
                if (flush_q != FLUSH_W'(FLUSH_CYCLES)) flush_d = flush_q + FLUSH_W'(1);
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    tx_d   = {tx_word_i[7:0], tx_word_i[15:8]};
                    cnt_d  = '0;
                    seen_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_d   = {rx_q[14:0], mosi_s};
                    seen_d = 1'b1;
                    if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
                end
                if (sck_fall && seen_q) tx_d = {tx_q[14:0], 1'b0};
            end
            ST_DONE: begin
                if (cnt_q == CNT_W'(FRAME_BITS)) begin
                    addr_d  = rx_q[7:0];
                    data_d  = rx_q[15:8];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_q          <= '0;
            tx_q          <= '0;
            cnt_q         <= '0;
            seen_q        <= 1'b0;
            flush_q       <= '0;
            cmd_addr_o    <= '0;
            cmd_data_o    <= '0;
            cmd_valid_o   <= 1'b0;
            frame_err_o   <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            flush_q       <= flush_d;
            cmd_addr_o    <= addr_d;
            cmd_data_o    <= data_d;
            cmd_valid_o   <= valid_d;
            frame_err_o   <= err_d;
            spi_miso_o    <= miso_d;
            spi_miso_oe_o <= oe_d;
            busy_o        <= busy_d;
        end
    end

endmodule
